// File: rtl/rand_arbiter_pkg.sv
// Shared types and constants for the random-word arbiter and its generator.
package rand_arbiter_pkg;

    // Arbiter FSM states; IDLE is the only non-busy state.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESEED  = 2'd1,
        ST_ADVANCE = 2'd2,
        ST_DELIVER = 2'd3
    } state_e;

    // A stride of zero would mean "no generator step"; it is replaced by this value.
    localparam logic [7:0] STRIDE_ZERO_SUB = 8'd1;

    // Width of the delivered-word counter.
    localparam int WORD_CNT_W = 32;

endpackage

// File: rtl/rand_arbiter_new_random.sv
// Xorshift pseudo-random generator (shifts 13/7/17) with synchronous reload.
// rs has priority over en; the register only changes when one of them is high.
// BITS must be at least 18 for the shift constants to be meaningful.
module new_random #(
    parameter int              BITS          = 64,
    parameter logic [BITS-1:0] INITIAL_VALUE = 64'h5083_e3e3_8587_694b
) (
    input  logic            clk,
    input  logic            rs,
    input  logic            en,
    output logic [BITS-1:0] o_value,
    output logic [BITS-1:0] o_next
);

    logic [BITS-1:0] r_state;
    logic [BITS-1:0] w_s1;
    logic [BITS-1:0] w_s2;

    // One xorshift step applied to the current state.
    always_comb begin
        w_s1   = r_state ^ (r_state << 13);
        w_s2   = w_s1 ^ (w_s1 >> 7);
        o_next = w_s2 ^ (w_s2 << 17);
    end

    // Reload on rs, advance one step on en, otherwise hold.
    always_ff @(posedge clk) begin
        if (rs) begin
            r_state <= INITIAL_VALUE;
        end else if (en) begin
            r_state <= o_next;
        end
    end

    assign o_value = r_state;

endmodule

// File: rtl/rand_arbiter.sv
// Round-robin arbiter sharing one random generator among N_REQ requesters.
// Handshake: a requester holds its req bit until it sees its gnt bit; gnt is a
// one-cycle pulse that also qualifies rnd_data. Once a winner is latched the
// grant always completes, even if that requester drops req in the meantime.
module rand_arbiter
    import rand_arbiter_pkg::*;
#(
    parameter int              N_REQ         = 4,
    parameter int              BITS          = 64,
    parameter logic [BITS-1:0] INITIAL_VALUE = 64'h5083_e3e3_8587_694b
) (
    input  logic                  clk,
    input  logic                  rs_n,
    input  logic [N_REQ-1:0]      req,
    input  logic [7:0]            stride,
    input  logic                  reseed,
    output logic [N_REQ-1:0]      gnt,
    output logic [BITS-1:0]       rnd_data,
    output logic                  busy,
    output logic [WORD_CNT_W-1:0] word_cnt,
    output state_e                o_dbg_state
);

    localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e                r_state;
    logic [N_REQ-1:0]      r_gnt;
    logic [BITS-1:0]       r_rnd_data;
    logic [WORD_CNT_W-1:0] r_word_cnt;
    logic                  r_reseed_pend;
    logic [LW-1:0]         r_last_winner;
    logic [LW-1:0]         r_winner;
    logic [7:0]            r_step_cnt;

    logic                  w_found;
    logic [LW-1:0]         w_pick;
    logic [LW-1:0]         w_cand;
    int                    w_idx;
    logic [N_REQ-1:0]      w_win_onehot;
    logic                  w_gen_en;
    logic                  w_gen_rs;
    logic [BITS-1:0]       w_gen_value;
    logic [BITS-1:0]       w_gen_next;

    // Round-robin search starting just after the previous winner.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        w_cand  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_idx  = (int'(r_last_winner) + i) % N_REQ;
            w_cand = LW'(w_idx);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    assign w_win_onehot = N_REQ'(1) << r_winner;

    // The generator only moves during ADVANCE and reloads on reset or RESEED.
    assign w_gen_en = (r_state == ST_ADVANCE);
    assign w_gen_rs = !rs_n || (r_state == ST_RESEED);

    new_random #(
        .BITS          (BITS),
        .INITIAL_VALUE (INITIAL_VALUE)
    ) u_gen (
        .clk     (clk),
        .rs      (w_gen_rs),
        .en      (w_gen_en),
        .o_value (w_gen_value),
        .o_next  (w_gen_next)
    );

    // Arbiter FSM with registered grant, data and word counter.
    always_ff @(posedge clk) begin
        if (!rs_n) begin
            r_state       <= ST_IDLE;
            r_gnt         <= '0;
            r_rnd_data    <= '0;
            r_word_cnt    <= '0;
            r_reseed_pend <= 1'b0;
            r_last_winner <= LW'(N_REQ - 1);
            r_winner      <= '0;
            r_step_cnt    <= '0;
        end else begin
            r_gnt <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (reseed || r_reseed_pend) begin
                        r_reseed_pend <= 1'b0;
                        r_state       <= ST_RESEED;
                    end else if (w_found) begin
                        r_winner   <= w_pick;
                        r_step_cnt <= (stride == 8'd0) ? STRIDE_ZERO_SUB : stride;
                        r_state    <= ST_ADVANCE;
                    end
                end
                ST_RESEED: begin
                    r_reseed_pend <= 1'b0;
                    r_state       <= ST_IDLE;
                end
                ST_ADVANCE: begin
                    if (reseed) begin
                        r_reseed_pend <= 1'b1;
                    end
                    r_step_cnt <= r_step_cnt - 8'd1;
                    if (r_step_cnt == 8'd1) begin
                        // Last step: capture the value the generator is moving to now.
                        r_gnt      <= w_win_onehot;
                        r_rnd_data <= w_gen_next;
                        r_state    <= ST_DELIVER;
                    end
                end
                ST_DELIVER: begin
                    if (reseed) begin
                        r_reseed_pend <= 1'b1;
                    end
                    r_last_winner <= r_winner;
                    r_word_cnt    <= r_word_cnt + 1'b1;
                    r_state       <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign rnd_data    = r_rnd_data;
    assign busy        = (r_state != ST_IDLE);
    assign word_cnt    = r_word_cnt;
    assign o_dbg_state = r_state;

    logic w_unused;
    assign w_unused = ^w_gen_value;

endmodule

// File: tb/tb_rand_arbiter.sv
// Randomized and directed bench for rand_arbiter against a countdown-based model.
module tb_rand_arbiter;
  import rand_arbiter_pkg::*;

  localparam int N = 4;
  localparam logic [63:0] SEED = 64'h5083_e3e3_8587_694b;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rs_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [7:0]  stride = 8'd1;
  logic        reseed = 1'b0;
  logic [N-1:0] gnt;
  logic [63:0] rnd_data;
  logic        busy;
  logic [31:0] word_cnt;
  state_e      dbg_state;

  rand_arbiter dut (
    .clk         (clk),
    .rs_n        (rs_n),
    .req         (req),
    .stride      (stride),
    .reseed      (reseed),
    .gnt         (gnt),
    .rnd_data    (rnd_data),
    .busy        (busy),
    .word_cnt    (word_cnt),
    .o_dbg_state (dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // One generator step of the xorshift sequence.
  function automatic logic [63:0] xs(input logic [63:0] x);
    logic [63:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

  function automatic logic [63:0] xs_n(input logic [63:0] x, input int n);
    logic [63:0] y;
    y = x;
    for (int i = 0; i < n; i++) y = xs(y);
    return y;
  endfunction

  // The arbiter is modelled as "cycles left until idle" plus the scheduled
  // grant; the word value is computed in one go when the winner is chosen.
  int          m_left  = 0;
  bit          m_grant = 0;
  bit          m_pend  = 0;
  int          m_last  = N - 1;
  int          m_win   = 0;
  logic [63:0] m_gen   = SEED;
  logic [63:0] m_data  = '0;
  logic [63:0] m_rnd   = '0;
  logic [31:0] m_cnt   = '0;
  logic [N-1:0] m_gnt  = '0;

  task automatic model_edge();
    int eff;
    if (!rs_n) begin
      m_left = 0; m_grant = 0; m_pend = 0; m_last = N - 1;
      m_gen = SEED; m_gnt = '0; m_rnd = '0; m_cnt = '0;
    end else if (m_left == 0) begin
      m_gnt = '0;
      if (reseed || m_pend) begin
        m_pend = 0; m_left = 1; m_grant = 0; m_gen = SEED;
      end else if (req != '0) begin
        for (int i = 1; i <= N; i++) begin
          if (req[(m_last + i) % N]) begin
            m_win = (m_last + i) % N;
            break;
          end
        end
        eff = (stride == 8'd0) ? 1 : int'(stride);
        m_gen = xs_n(m_gen, eff);
        m_data = m_gen;
        m_left = eff + 1;
        m_grant = 1;
      end
    end else begin
      if (reseed && m_grant) m_pend = 1;
      m_left--;
      m_gnt = '0;
      if (m_grant && m_left == 1) begin
        m_gnt = N'(1) << m_win;
        m_rnd = m_data;
      end
      if (m_grant && m_left == 0) begin
        m_cnt++;
        m_last = m_win;
        m_grant = 0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step_cycle();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check("gnt", 64'(gnt), 64'(m_gnt));
    check("busy", 64'(busy), 64'(m_left != 0));
    check("rnd_data", rnd_data, m_rnd);
    check("word_cnt", 64'(word_cnt), 64'(m_cnt));
  endtask

  task automatic do_reset();
    rs_n = 1'b0; req = '0; reseed = 1'b0;
    repeat (2) step_cycle();
    rs_n = 1'b1;
  endtask

  // Holds req until granted (bits dropped once granted), then one more cycle.
  task automatic run_until_grant(output int k, output logic [N-1:0] g, output logic [63:0] d);
    k = 0; g = '0; d = '0;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      step_cycle();
      if (gnt != '0) begin
        k = i; g = gnt; d = rnd_data;
      end
      req = req & ~m_gnt;
    end
    check("grant_timeout", 64'(k != 0), 64'd1);
    step_cycle();
  endtask

  // ---------------- scoreboard for the round-robin sweep ----------------
  logic [63:0]  exp_q[$];
  logic [N-1:0] obs_g[$];
  int           obs_c[$];
  logic [63:0]  obs_d[$];
  logic [N-1:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  // ---------------- stimulus ----------------
  initial begin
    int k;
    logic [N-1:0] g;
    logic [63:0] d;

    // reset state
    do_reset();
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    // first grant after reset, stride 1
    stride = 8'd1; req = 4'b0001;
    run_until_grant(k, g, d);
    check("first_latency", 64'(k), 64'd2);
    check("first_gnt", 64'(g), 64'b0001);
    check("first_data", d, xs_n(SEED, 1));
    check("first_cnt", 64'(word_cnt), 64'd1);

    // round-robin sweep with all requesters, stride 3
    do_reset();
    stride = 8'd3; req = 4'b1111;
    for (int i = 1; i <= 5; i++) exp_q.push_back(xs_n(SEED, 3 * i));
    for (int i = 0; i < 25; i++) begin
      step_cycle();
      if (gnt != '0) begin
        obs_g.push_back(gnt); obs_c.push_back(cyc); obs_d.push_back(rnd_data);
      end
    end
    req = '0;
    step_cycle();
    check("rr_count", 64'(obs_g.size()), 64'd5);
    for (int i = 0; i < 5 && i < obs_g.size(); i++) begin
      check("rr_gnt", 64'(obs_g[i]), 64'(exp_g[i]));
      check("rr_data", obs_d[i], exp_q.pop_front());
      if (i > 0) check("rr_spacing", 64'(obs_c[i] - obs_c[i-1]), 64'd5);
    end

    // stride 0 behaves as stride 1
    stride = 8'd0; req = 4'b0010;
    run_until_grant(k, g, d);
    check("s0_latency", 64'(k), 64'd2);
    check("s0_gnt", 64'(g), 64'b0010);

    // reseed during a 4-step grant: grant completes, then RESEED, then fresh word
    stride = 8'd4; req = 4'b0001;
    step_cycle(); step_cycle();
    reseed = 1'b1;
    step_cycle();
    reseed = 1'b0; stride = 8'd9;
    run_until_grant(k, g, d);
    check("rs_grant_latency", 64'(k), 64'd2);
    check("rs_grant_gnt", 64'(g), 64'b0001);
    stride = 8'd1; req = 4'b0010;
    run_until_grant(k, g, d);
    check("post_reseed_latency", 64'(k), 64'd4);
    check("post_reseed_data", d, xs_n(SEED, 1));

    // reset in the middle of ADVANCE abandons the grant
    stride = 8'd5; req = 4'b0001;
    step_cycle(); step_cycle();
    rs_n = 1'b0; req = '0;
    step_cycle();
    rs_n = 1'b1;
    check("midrst_gnt", 64'(gnt), 64'd0);
    check("midrst_rnd", rnd_data, 64'd0);
    check("midrst_cnt", 64'(word_cnt), 64'd0);
    for (int i = 0; i < 6; i++) begin
      step_cycle();
      check("midrst_nognt", 64'(gnt), 64'd0);
    end
    stride = 8'd1; req = 4'b0100;
    run_until_grant(k, g, d);
    check("midrst_next_gnt", 64'(g), 64'b0100);
    check("midrst_next_data", d, xs_n(SEED, 1));

    // word counter wrap
    force dut.r_word_cnt = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    step_cycle();
    release dut.r_word_cnt;
    step_cycle();
    stride = 8'd2; req = 4'b1000;
    run_until_grant(k, g, d);
    check("wrap_cnt", 64'(word_cnt), 64'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rs_n   = ($urandom_range(0, 99) != 0);
      reseed = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) stride = 8'($urandom_range(0, 5));
      step_cycle();
      req = req & ~m_gnt;
    end
    rs_n = 1'b1; reseed = 1'b0; req = '0;
    repeat (10) step_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rand_arbiter.md
RAND_ARBITER -- requirements
Module: rand_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4: number of requesters sharing one generator.
REQ-002 The block SHALL have parameter BITS, default 64: random word width.
REQ-003 The block SHALL have parameter INITIAL_VALUE, default 64'h5083_e3e3_8587_694b: generator seed passed to the sub-module.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all logic on rising edge.
REQ-005 The block SHALL have port rs_n, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port req, input, N_REQ bits: per-requester word request, held until granted.
REQ-007 The block SHALL have port stride, input, 8 bits: generator steps per delivered word, sampled at arbitration.
REQ-008 The block SHALL have port reseed, input, 1 bit: single-cycle pulse requesting generator reload to INITIAL_VALUE.
REQ-009 The block SHALL have port gnt, output, N_REQ bits: one-hot grant, doubling as data-valid for the winner.
REQ-010 The block SHALL have port rnd_data, output, BITS bits: word delivered with gnt.
REQ-011 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-012 The block SHALL have port word_cnt, output, 32 bits: count of delivered words.

Function
REQ-013 The FSM SHALL have states IDLE, RESEED, ADVANCE and DELIVER.
REQ-014 In IDLE, a pending reseed SHALL take priority over requests; the next state SHALL be RESEED.
REQ-015 In IDLE with any req bit set and no pending reseed, the block SHALL pick a winner round-robin, searching from last_winner+1 modulo N_REQ.
REQ-016 On that pick, the block SHALL latch the winner and load step_cnt with stride, treating stride 0 as 1, then go to ADVANCE.
REQ-017 In ADVANCE, the generator enable SHALL be high every cycle and step_cnt SHALL decrement.
REQ-018 ADVANCE SHALL last exactly the effective stride in cycles, then go to DELIVER.
REQ-019 In DELIVER, gnt SHALL equal the one-hot winner for exactly one cycle.
REQ-020 In DELIVER, rnd_data SHALL equal the generator output after all steps, registered and held until the next DELIVER.
REQ-021 In DELIVER, last_winner SHALL be updated and word_cnt SHALL increment, wrapping 0xFFFFFFFF to 0.
REQ-022 DELIVER SHALL always return to IDLE, so back-to-back grants are separated by at least one IDLE cycle.
REQ-023 Latency SHALL be req seen in IDLE at cycle T, gnt at cycle T+1+effective stride.
REQ-024 RESEED SHALL drive the generator reset high for one cycle and then return to IDLE.
REQ-025 A reseed pulse arriving in ADVANCE or DELIVER SHALL be latched as pending and serviced at the next IDLE.
REQ-026 Any grant in progress SHALL complete before a pending reseed is serviced.
REQ-027 A winner dropping req before gnt SHALL still receive its grant, i.e. the grant is not cancelled.
REQ-028 stride changes outside IDLE SHALL have no effect on the grant in progress.
REQ-029 The generator enable SHALL be low in IDLE, RESEED and DELIVER, so the generator never advances outside ADVANCE.

Reset
REQ-030 With rs_n low at a rising edge, the FSM SHALL enter IDLE, and gnt, rnd_data and word_cnt SHALL be 0.
REQ-031 With rs_n low at a rising edge, busy SHALL be 0, pending reseed SHALL be cleared, and last_winner SHALL be N_REQ-1 so requester 0 wins first.
REQ-032 The generator reset SHALL be high whenever rs_n is low, which reloads INITIAL_VALUE.
REQ-033 Reset mid-ADVANCE SHALL abandon the grant with no gnt pulse.

Structure
REQ-034 A shared package SHALL hold the FSM state enum, the stride-0 substitute constant and the word_cnt width constant.
REQ-035 The generator SHALL be the single sub-module: new_random, parameterised with BITS and INITIAL_VALUE.
REQ-036 The sub-module en SHALL be driven only by the ADVANCE decode, and its rs only by (!rs_n or state==RESEED).

Verification
REQ-037 After reset, stride=1 and req=0001 at T SHALL give gnt=0001 at T+2 only, rnd_data equal to a 1-step model from 5083_e3e3_8587_694b, and word_cnt=1.
REQ-038 With req=1111 held and stride=3, gnts SHALL be 0001,0010,0100,1000,0001, each 5 cycles apart, with rnd_data matching the model at 3,6,9,12,15 steps.
REQ-039 stride=0 SHALL behave identically to stride=1, with gnt at T+2.
REQ-040 A reseed during ADVANCE of a 4-step grant SHALL complete that grant, then pass through RESEED, and the next stride=1 word SHALL equal the 1-step model value.
REQ-041 rs_n low for one cycle mid-ADVANCE SHALL produce no gnt, and outputs SHALL read 0; a following req=0100 SHALL be granted with the 1-step model value.
REQ-042 With word_cnt forced to 0xFFFFFFFF, one grant SHALL wrap word_cnt to 0.
